// File: rtl/vector_instr_queue.sv
// Decoupling FIFO between the scalar core's 96-bit vector channel and the vector issue stage.
// Optional same-cycle empty-queue bypass is enabled by defining VQ_BYPASS_EN.
module vector_instr_queue #(
  parameter int unsigned DATA_FROM_SCALAR = 96,
  parameter int unsigned WIDTH            = 32,
  parameter int unsigned DEPTH            = 4,
  parameter int unsigned CNT_W            = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_FROM_SCALAR-1:0] in_dat,
  input  logic                        in_vld,
  output logic                        in_rdy,
  input  logic                        flush,
  output logic [WIDTH-1:0]            out_instr,
  output logic [WIDTH-1:0]            out_op1,
  output logic [WIDTH-1:0]            out_op2,
  output logic                        out_is_vsetvl,
  output logic                        out_vld,
  input  logic                        out_rdy,
  output logic [CNT_W-1:0]            count,
  output logic [15:0]                 drop_cnt
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam logic [6:0]  OpV   = 7'b1010111;
  localparam logic [6:0]  OpLdV = 7'b0000111;
  localparam logic [6:0]  OpStV = 7'b0100111;

  if (DATA_FROM_SCALAR != 3 * WIDTH) begin : gen_width_check
    $error("DATA_FROM_SCALAR must equal 3*WIDTH");
  end

  logic [DATA_FROM_SCALAR-1:0] mem [DEPTH];
  logic [PtrW-1:0]             rdPtr;
  logic [PtrW-1:0]             wrPtr;
  logic [CNT_W-1:0]            cnt;
  logic                        notFull;
  logic                        notEmpty;
  logic                        isVecOp;
  logic                        pushHs;
  logic                        bypassVld;
  logic                        wrEn;
  logic                        rdEn;
  logic [DATA_FROM_SCALAR-1:0] outWord;

  assign count    = cnt;
  assign notFull  = (cnt != CNT_W'(DEPTH));
  assign notEmpty = (cnt != '0);
  assign isVecOp  = (in_dat[6:0] == OpV) || (in_dat[6:0] == OpLdV) || (in_dat[6:0] == OpStV);

  // in_rdy deliberately ignores out_rdy so there is no ready path through the queue.
  assign in_rdy = rst & notFull & ~flush;
  assign pushHs = in_vld & in_rdy;

`ifdef VQ_BYPASS_EN
  assign bypassVld = pushHs & isVecOp & ~notEmpty;
  assign outWord   = notEmpty  ? mem[rdPtr] :
                     bypassVld ? in_dat     : '0;
`else
  assign bypassVld = 1'b0;
  assign outWord   = notEmpty ? mem[rdPtr] : '0;
`endif

  // A bypassed word that is taken immediately never touches storage.
  assign wrEn    = pushHs & isVecOp & ~(bypassVld & out_rdy);
  assign rdEn    = notEmpty & out_rdy;
  assign out_vld = notEmpty | bypassVld;

  assign out_instr     = outWord[WIDTH-1:0];
  assign out_op1       = outWord[WIDTH +: WIDTH];
  assign out_op2       = outWord[2*WIDTH +: WIDTH];
  assign out_is_vsetvl = (outWord[6:0] == OpV) && (outWord[14:12] == 3'b111);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      cnt      <= '0;
      drop_cnt <= '0;
    end else begin
      if (flush) begin
        rdPtr <= '0;
        wrPtr <= '0;
        cnt   <= '0;
      end else begin
        if (wrEn) wrPtr <= wrPtr + PtrW'(1);
        if (rdEn) rdPtr <= rdPtr + PtrW'(1);
        case ({wrEn, rdEn})
          2'b10:   cnt <= cnt + CNT_W'(1);
          2'b01:   cnt <= cnt - CNT_W'(1);
          default: cnt <= cnt;
        endcase
      end
      if (pushHs && !isVecOp && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrPtr] <= in_dat;
  end

endmodule

// File: tb/tb_vector_instr_queue.sv
// Directed self-checking bench for vector_instr_queue with a queue-based scoreboard model.
// Honours VQ_BYPASS_EN in its model when the macro is defined.
module tb_vector_instr_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [95:0] in_dat;
  logic        in_vld;
  logic        in_rdy;
  logic        flush;
  logic [31:0] out_instr;
  logic [31:0] out_op1;
  logic [31:0] out_op2;
  logic        out_is_vsetvl;
  logic        out_vld;
  logic        out_rdy;
  logic [2:0]  count;
  logic [15:0] drop_cnt;

  vector_instr_queue #(
    .DATA_FROM_SCALAR(96),
    .WIDTH(32),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_dat(in_dat),
    .in_vld(in_vld),
    .in_rdy(in_rdy),
    .flush(flush),
    .out_instr(out_instr),
    .out_op1(out_op1),
    .out_op2(out_op2),
    .out_is_vsetvl(out_is_vsetvl),
    .out_vld(out_vld),
    .out_rdy(out_rdy),
    .count(count),
    .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          nTests = 0;
  int          nFail  = 0;
  logic [95:0] mq[$];
  int unsigned mDrop  = 0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic isVec(input logic [95:0] w);
    return (w[6:0] == 7'h57) || (w[6:0] == 7'h07) || (w[6:0] == 7'h27);
  endfunction

  function automatic logic [95:0] mk(input logic [31:0] op2, input logic [31:0] op1,
                                     input logic [31:0] ins);
    return {op2, op1, ins};
  endfunction

  // One clock cycle: drive, check outputs against the model, advance the model, clock.
  task automatic step(input logic [95:0] d, input logic v, input logic ordy, input logic fl);
    logic        expRdy;
    logic        byp;
    logic        expVld;
    logic [95:0] head;
    @(negedge clk);
    in_dat  = d;
    in_vld  = v;
    out_rdy = ordy;
    flush   = fl;
    #1;
    expRdy = (mq.size() != DEPTH) && !fl;
    byp    = 1'b0;
`ifdef VQ_BYPASS_EN
    byp = (mq.size() == 0) && v && expRdy && isVec(d);
`endif
    expVld = (mq.size() != 0) || byp;
    head   = (mq.size() != 0) ? mq[0] : (byp ? d : 96'h0);
    chk("in_rdy", 96'(in_rdy), 96'(expRdy));
    chk("out_vld", 96'(out_vld), 96'(expVld));
    chk("out_word", {out_op2, out_op1, out_instr}, head);
    chk("out_is_vsetvl", 96'(out_is_vsetvl),
        96'((head[6:0] == 7'h57) && (head[14:12] == 3'b111)));
    chk("count", 96'(count), 96'(mq.size()));
    chk("drop_cnt", 96'(drop_cnt), 96'(mDrop));
    if (v && expRdy) begin
      if (isVec(d)) mq.push_back(d);
      else if (mDrop != 32'hFFFF) mDrop++;
    end
    if (expVld && ordy) void'(mq.pop_front());
    if (fl) mq.delete();
    @(posedge clk);
  endtask

  task automatic idle(input logic ordy);
    step(96'h0, 1'b0, ordy, 1'b0);
  endtask

  logic [6:0] opSel [3];

  initial begin
    opSel[0] = 7'h57;
    opSel[1] = 7'h07;
    opSel[2] = 7'h27;
    rst     = 1'b0;
    in_dat  = '0;
    in_vld  = 1'b0;
    out_rdy = 1'b0;
    flush   = 1'b0;

    // Reset state
    #3;
    chk("rst_count", 96'(count), 96'h0);
    chk("rst_out_vld", 96'(out_vld), 96'h0);
    chk("rst_in_rdy", 96'(in_rdy), 96'h0);
    chk("rst_drop_cnt", 96'(drop_cnt), 96'h0);
    @(negedge clk);
    rst = 1'b1;

    // vsetvl word, popped the cycle after it appears
    step(96'h00000000_00000005_00A07057, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Fill to full with out_rdy low; fifth word held until a pop frees space
    for (int i = 0; i < 5; i++) step(mk(32'(i), 32'(100 + i), {25'(i), 7'h57}), 1'b1, 1'b0, 1'b0);
    step(mk(32'd4, 32'd104, {25'd4, 7'h57}), 1'b1, 1'b1, 1'b0);
    step(mk(32'd4, 32'd104, {25'd4, 7'h57}), 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Non-vector opcode is consumed and dropped
    step(mk(32'h1, 32'h2, 32'h00B50533), 1'b1, 1'b1, 1'b0);
    idle(1'b1);

    // Flush with three entries queued and a word offered on the flush cycle
    for (int i = 0; i < 3; i++) step(mk($urandom, $urandom, {25'(i), 7'h27}), 1'b1, 1'b0, 1'b0);
    step(mk(32'hA, 32'hB, 32'h0000_7057), 1'b1, 1'b0, 1'b1);
    idle(1'b1);

    // Streaming at one word per cycle across pointer wrap, mixing accepted opcodes
    for (int i = 0; i < 2 * DEPTH + 3; i++)
      step(mk($urandom, $urandom, {$urandom_range(0, 32'h1FF_FFFF), opSel[i % 3]}),
           1'b1, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Async reset mid-burst with two entries queued
    step(mk(32'h11, 32'h22, 32'h0000_1057), 1'b1, 1'b0, 1'b0);
    step(mk(32'h33, 32'h44, 32'h0000_2057), 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    in_vld = 1'b0;
    #1;
    chk("pre_rst_count", 96'(count), 96'h2);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_count", 96'(count), 96'h0);
    chk("async_rst_out_vld", 96'(out_vld), 96'h0);
    chk("async_rst_in_rdy", 96'(in_rdy), 96'h0);
    chk("async_rst_drop_cnt", 96'(drop_cnt), 96'h0);
    mq.delete();
    mDrop = 0;
    @(negedge clk);
    rst = 1'b1;
    idle(1'b1);

    // Single word into an empty queue with out_rdy high (bypasses when enabled)
    step(mk(32'h55, 32'h66, 32'h0000_3057), 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    // Empty queue, out_rdy low: word must be stored and shown afterwards
    step(mk(32'h77, 32'h88, 32'h0000_4007), 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
